// File: rtl/fwd_sb_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
package fwd_sb_pkg;

    localparam int unsigned RD_W   = 16;
    localparam int unsigned SEL_RF = 0;

    // rd is stored zero-extended to RD_W so the struct is independent of ADDR_W
    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            regwrite;
        logic            load;
    } fwd_entry_t;

    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_sb_match.sv
// Priority comparator for one EX source operand against the post-EX stage entries.
module fwd_sb_match
    import fwd_sb_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned SEL_W  = 2
) (
    input  fwd_entry_t [DEPTH-1:0] entries_i,
    input  logic [ADDR_W-1:0]      src_i,
    input  logic                   use_i,
    input  logic                   ex_valid_i,
    input  logic                   flush_i,
    output logic [SEL_W-1:0]       sel_c_o,
    output logic                   load_use_c_o
);

    logic [SEL_W-1:0] lowest_c;

    // Scan oldest to youngest so the youngest matching producer ends up selected
    always_comb begin
        lowest_c = SEL_W'(SEL_RF);
        for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
            if (entries_i[s].valid && entries_i[s].regwrite &&
                (entries_i[s].rd == RD_W'(src_i)) && (src_i != '0) &&
                use_i && ex_valid_i) begin
                lowest_c = SEL_W'(s + 1);
            end
        end
    end

    assign load_use_c_o = (lowest_c == SEL_W'(1)) && entries_i[0].load && !flush_i;
    assign sel_c_o      = (flush_i || load_use_c_o) ? SEL_W'(SEL_RF) : lowest_c;

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding / load-use scoreboard for the EX stage.
// Optional statistics counters are enabled with `define FWD_SB_STATS_EN.
module fwd_scoreboard
    import fwd_sb_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned NSRC   = 2,
    localparam int unsigned SEL_W = sel_width(DEPTH)
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    ex_valid,
    input  logic [ADDR_W-1:0]       ex_rd,
    input  logic                    ex_regwrite,
    input  logic                    ex_load,
    input  logic [NSRC*ADDR_W-1:0]  ex_src_addr,
    input  logic [NSRC-1:0]         ex_src_use,
    input  logic                    flush,
    input  logic                    ext_hold,
    output logic [NSRC*SEL_W-1:0]   fwd_sel,
    output logic                    stall
`ifdef FWD_SB_STATS_EN
    ,
    output logic [31:0]             stat_stall_cnt,
    output logic [31:0]             stat_fwd_cnt
`endif
);

    fwd_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [NSRC-1:0]        load_use_c;

    for (genvar k = 0; k < int'(NSRC); k++) begin : g_src
        fwd_sb_match #(
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_match (
            .entries_i    (entries_q),
            .src_i        (ex_src_addr[k*ADDR_W +: ADDR_W]),
            .use_i        (ex_src_use[k]),
            .ex_valid_i   (ex_valid),
            .flush_i      (flush),
            .sel_c_o      (fwd_sel[k*SEL_W +: SEL_W]),
            .load_use_c_o (load_use_c[k])
        );
    end

    assign stall = ex_valid && !flush && (|load_use_c);

    // Advance the stage mirror; a stalled or flushed EX slot enters as a bubble
    always_comb begin
        entries_d = entries_q;
        if (!ext_hold) begin
            for (int s = int'(DEPTH) - 1; s >= 1; s--) begin
                entries_d[s] = entries_q[s-1];
            end
            entries_d[0] = '0;
            if (ex_valid && !flush && !stall) begin
                entries_d[0].valid    = 1'b1;
                entries_d[0].rd       = RD_W'(ex_rd);
                entries_d[0].regwrite = ex_regwrite;
                entries_d[0].load     = ex_load;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

`ifdef FWD_SB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    // Saturating event counters, frozen while the pipeline is held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (!ext_hold) begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if ((fwd_sel != '0) && (fwd_cnt_q != '1)) begin
                fwd_cnt_d = fwd_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: directed hazard scenarios then random traffic.
module tb_fwd_scoreboard;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 3;
    localparam int unsigned NSRC   = 2;
    localparam int unsigned SEL_W  = 2;

    logic                   Clk;
    logic                   Reset;
    logic                   ex_valid;
    logic [ADDR_W-1:0]      ex_rd;
    logic                   ex_regwrite;
    logic                   ex_load;
    logic [NSRC*ADDR_W-1:0] ex_src_addr;
    logic [NSRC-1:0]        ex_src_use;
    logic                   flush;
    logic                   ext_hold;
    logic [NSRC*SEL_W-1:0]  fwd_sel;
    logic                   stall;
`ifdef FWD_SB_STATS_EN
    logic [31:0]            stat_stall_cnt;
    logic [31:0]            stat_fwd_cnt;
`endif

    fwd_scoreboard #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NSRC(NSRC)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ex_valid       (ex_valid),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_load        (ex_load),
        .ex_src_addr    (ex_src_addr),
        .ex_src_use     (ex_src_use),
        .flush          (flush),
        .ext_hold       (ext_hold),
        .fwd_sel        (fwd_sel),
        .stall          (stall)
`ifdef FWD_SB_STATS_EN
        ,
        .stat_stall_cnt (stat_stall_cnt),
        .stat_fwd_cnt   (stat_fwd_cnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [NSRC*SEL_W-1:0] sel;
        logic                  stl;
        logic [31:0]           scnt;
        logic [31:0]           fcnt;
        int                    cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference pipeline: index 0 is the instruction one stage past EX
    bit          m_valid [DEPTH];
    int          m_rd    [DEPTH];
    bit          m_rw    [DEPTH];
    bit          m_ld    [DEPTH];
    bit          m_known = 1'b0;
    logic [31:0] m_scnt  = '0;
    logic [31:0] m_fcnt  = '0;

    task automatic step(input bit rst, input bit v, input int rd, input bit rw,
                        input bit ld, input int s0, input int s1,
                        input bit [1:0] use_k, input bit fl, input bit hold);
        exp_t e;
        int   src [NSRC];
        int   low [NSRC];
        bit   hz  [NSRC];
        bit   st;
        bit   anyfwd;
        int   sel [NSRC];
        Reset       = rst;
        ex_valid    = v;
        ex_rd       = ADDR_W'(rd);
        ex_regwrite = rw;
        ex_load     = ld;
        ex_src_addr = {ADDR_W'(s1), ADDR_W'(s0)};
        ex_src_use  = use_k;
        flush       = fl;
        ext_hold    = hold;
        src[0] = s0;
        src[1] = s1;
        st     = 1'b0;
        anyfwd = 1'b0;
        for (int k = 0; k < int'(NSRC); k++) begin
            bit found = 1'b0;
            low[k] = 0;
            for (int s = 0; s < int'(DEPTH); s++) begin
                if (!found && m_valid[s] && m_rw[s] && m_rd[s] == src[k] &&
                    src[k] != 0 && use_k[k] && v) begin
                    low[k] = s + 1;
                    found  = 1'b1;
                end
            end
            hz[k] = (low[k] == 1) && m_ld[0];
            if (hz[k] && v && !fl) st = 1'b1;
            sel[k] = (fl || hz[k]) ? 0 : low[k];
            if (sel[k] != 0) anyfwd = 1'b1;
        end
        if (m_known) begin
            e.sel  = {SEL_W'(sel[1]), SEL_W'(sel[0])};
            e.stl  = st;
            e.scnt = m_scnt;
            e.fcnt = m_fcnt;
            e.cyc  = cyc;
            q.push_back(e);
        end
        @(posedge Clk);
        cyc++;
        if (rst) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                m_valid[s] = 1'b0; m_rd[s] = 0; m_rw[s] = 1'b0; m_ld[s] = 1'b0;
            end
            m_scnt  = '0;
            m_fcnt  = '0;
            m_known = 1'b1;
        end else if (!hold) begin
            if (st && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
            if (anyfwd && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 32'd1;
            for (int s = int'(DEPTH) - 1; s >= 1; s--) begin
                m_valid[s] = m_valid[s-1]; m_rd[s] = m_rd[s-1];
                m_rw[s]    = m_rw[s-1];    m_ld[s] = m_ld[s-1];
            end
            if (v && !fl && !st) begin
                m_valid[0] = 1'b1; m_rd[0] = rd; m_rw[0] = rw; m_ld[0] = ld;
            end else begin
                m_valid[0] = 1'b0; m_rd[0] = 0; m_rw[0] = 1'b0; m_ld[0] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation
    exp_t me;
    always @(negedge Clk) begin
        if (q.size() != 0) begin
            me = q.pop_front();
            n_tests++;
            if (fwd_sel !== me.sel) begin
                n_fail++;
                $display("FAIL fwd_sel cyc=%0d got=%h exp=%h", me.cyc, fwd_sel, me.sel);
            end
            n_tests++;
            if (stall !== me.stl) begin
                n_fail++;
                $display("FAIL stall cyc=%0d got=%b exp=%b", me.cyc, stall, me.stl);
            end
`ifdef FWD_SB_STATS_EN
            n_tests++;
            if (stat_stall_cnt !== me.scnt) begin
                n_fail++;
                $display("FAIL stat_stall_cnt cyc=%0d got=%0d exp=%0d", me.cyc, stat_stall_cnt, me.scnt);
            end
            n_tests++;
            if (stat_fwd_cnt !== me.fcnt) begin
                n_fail++;
                $display("FAIL stat_fwd_cnt cyc=%0d got=%0d exp=%0d", me.cyc, stat_fwd_cnt, me.fcnt);
            end
`endif
        end
    end

    initial begin
        // Reset; the first cycle has unknown state and is not checked
        step(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        idle();

        // ALU producer forwarded from entry 1
        step(0, 1, 3, 1, 0, 0, 0, 2'b00, 0, 0);
        step(0, 1, 9, 1, 0, 3, 0, 2'b01, 0, 0);

        // Load-use on operand 1, from a clean reset so stats read 1/1
        step(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        step(0, 1, 5, 1, 1, 0, 0, 2'b00, 0, 0);
        step(0, 1, 6, 1, 0, 0, 5, 2'b10, 0, 0);
        step(0, 1, 6, 1, 0, 0, 5, 2'b10, 0, 0);
        idle();

        // Youngest producer wins; r0 is never forwarded
        step(0, 1, 7, 1, 0, 0, 0, 2'b00, 0, 0);
        step(0, 1, 7, 1, 0, 0, 0, 2'b00, 0, 0);
        step(0, 1, 8, 1, 0, 7, 7, 2'b11, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0);
        step(0, 1, 8, 1, 0, 0, 0, 2'b01, 0, 0);

        // Load-use held for three cycles, then released
        step(0, 1, 5, 1, 1, 0, 0, 2'b00, 0, 0);
        repeat (3) step(0, 1, 6, 1, 0, 5, 0, 2'b01, 0, 1);
        step(0, 1, 6, 1, 0, 5, 0, 2'b01, 0, 0);
        step(0, 1, 6, 1, 0, 5, 0, 2'b01, 0, 0);
        repeat (3) idle();

        // Flush kills the hazard; reset mid-hazard discards the load
        step(0, 1, 5, 1, 1, 0, 0, 2'b00, 0, 0);
        step(0, 1, 6, 1, 0, 5, 0, 2'b01, 1, 0);
        step(0, 1, 6, 1, 0, 5, 0, 2'b01, 0, 0);
        step(0, 1, 5, 1, 1, 0, 0, 2'b00, 0, 0);
        step(0, 1, 6, 1, 0, 5, 0, 2'b01, 0, 1);
        step(1, 1, 6, 1, 0, 5, 0, 2'b01, 0, 1);
        step(0, 1, 6, 1, 0, 5, 5, 2'b11, 0, 0);

        // Random traffic over a small register range to provoke matches
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) < 2),
                 ($urandom_range(99) < 85),
                 int'($urandom_range(7)),
                 ($urandom_range(99) < 70),
                 ($urandom_range(99) < 30),
                 int'($urandom_range(7)),
                 int'($urandom_range(7)),
                 2'($urandom_range(3)),
                 ($urandom_range(99) < 10),
                 ($urandom_range(99) < 15));
        end

        idle();
        repeat (2) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W  5  register-address width
  DEPTH  3  tracked post-EX stages (1=EX/MEM, 2=MEM/WB, 3=post-WB)
  NSRC  2  EX-stage source operands
  SEL_W = $clog2(DEPTH+1), derived, not overridable.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  Clk  in  1  single clock; all state on rising edge
  Reset  in  1  synchronous, active-high reset
  ex_valid  in  1  EX holds a live instruction
  ex_rd  in  ADDR_W  EX destination register
  ex_regwrite  in  1  EX instruction writes register file
  ex_load  in  1  EX instruction is a load (result ready after MEM)
  ex_src_addr  in  NSRC*ADDR_W  operand k at bits [k*ADDR_W +: ADDR_W]
  ex_src_use  in  NSRC  operand k read from register file (0 = immediate/unused)
  flush  in  1  kill EX instruction this cycle
  ext_hold  in  1  external pipeline freeze (memory wait)
  fwd_sel  out  NSRC*SEL_W  per operand: 0 = register file, s = stage s
  stall  out  1  load-use hazard; hold IF/ID/EX one cycle

Function
REQ-003 Block SHALL keep DEPTH entries {valid, rd, regwrite, load}; entry s mirrors instruction in stage s.
REQ-004 On each edge with ext_hold=0: entry[s] <= entry[s-1] for s>=2; entry[1] <= EX fields if ex_valid & ~flush & ~stall, else invalid bubble.
REQ-005 With ext_hold=1 all entries SHALL hold; ext_hold overrides stall and flush for state update.
REQ-006 Entry s matches operand k when valid & regwrite & rd==src_k & src_k!=0 & ex_src_use[k] & ex_valid.
REQ-007 fwd_sel[k] SHALL be the lowest matching s (youngest producer wins), else 0; combinational, zero latency.
REQ-008 stall SHALL be 1 when some operand's lowest match is entry 1 with load=1, and ex_valid & ~flush; that operand's fwd_sel SHALL then be 0.
REQ-009 Stall cycle inserts bubble into entry 1 (REQ-004), so next cycle the load sits in entry 2 and fwd_sel=2; stall SHALL never last beyond one non-held cycle per hazard.
REQ-010 flush SHALL force stall=0 and fwd_sel=0 that cycle.
REQ-011 Register 0 SHALL never be forwarded or cause stall.

Reset
REQ-012 Reset=1 at an edge SHALL invalidate all entries; with entries invalid, fwd_sel=0 and stall=0 follow combinationally.
REQ-013 Reset SHALL override ext_hold, flush and stall; reset mid-hazard discards the pending load.

Configuration
REQ-014 Macro FWD_SB_STATS_EN, when defined, SHALL add outputs stat_stall_cnt[31:0] and stat_fwd_cnt[31:0]: +1 per non-held cycle with stall=1; +1 per non-held cycle with any fwd_sel!=0; saturate at 0xFFFFFFFF; cleared by Reset.
REQ-015 Without FWD_SB_STATS_EN those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-016 Package fwd_sb_pkg SHALL hold the entry struct typedef, SEL_RF=0 constant and SEL_W helper function.
REQ-017 Sub-module fwd_sb_match SHALL implement one operand's priority comparator; instantiated NSRC times via generate.

Verification
REQ-018 Reset, then EX add r3 (regwrite) one cycle, next EX src0=r3 use=1 -> fwd_sel[0]=1, stall=0.
REQ-019 EX lw r5 (load), next EX src1=r5 -> stall=1, fwd_sel[1]=0 for one cycle; following cycle stall=0, fwd_sel[1]=2.
REQ-020 Producers r7 in entries 1 and 2, src0=r7 -> fwd_sel[0]=1; src0=r0 with producer r0 -> fwd_sel[0]=0.
REQ-021 Load-use hazard with ext_hold=1 for 3 cycles -> stall held, entries frozen; on release stall clears after one cycle, fwd_sel=2.
REQ-022 Load-use hazard with flush=1 -> stall=0, fwd_sel=0, entry 1 invalid next cycle; Reset mid-hazard -> all outputs 0 next cycle.
REQ-023 With FWD_SB_STATS_EN: REQ-019 sequence -> stat_stall_cnt=1, stat_fwd_cnt=1.
